// File: rtl/or_sched_pkg.sv
// Shared definitions for the OR-reduction scheduler: FSM encoding and slice sizing.
package or_sched_pkg;

  localparam int DATA_WIDTH = 32;
  localparam int SLICES     = DATA_WIDTH / 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int slices_of(input int width);
    return width / 8;
  endfunction

endpackage

// File: rtl/or_reduce_sched_if.sv
// Requester, result and shared-reducer signals of the OR-reduction scheduler.
interface or_reduce_sched_if
  import or_sched_pkg::*;
#(parameter int WIDTH = DATA_WIDTH);

  logic             req0_valid;
  logic [WIDTH-1:0] req0_data;
  logic             req0_ready;
  logic             req1_valid;
  logic [WIDTH-1:0] req1_data;
  logic             req1_ready;
  logic             res_valid;
  logic             res_ready;
  logic             res_or;
  logic             res_id;
  logic [7:0]       red_in;
  logic             red_out;
  logic             busy;

  modport master (
    output req0_valid, req0_data, req1_valid, req1_data, res_ready, red_out,
    input  req0_ready, req1_ready, res_valid, res_or, res_id, red_in, busy
  );

  modport slave (
    input  req0_valid, req0_data, req1_valid, req1_data, res_ready, red_out,
    output req0_ready, req1_ready, res_valid, res_or, res_id, red_in, busy
  );

endinterface

// File: rtl/rr_arb2.sv
// Two-way round-robin grant: on a tie the requester that did not win last time gets it.
module rr_arb2 (
  input  logic [1:0] valid,
  input  logic       last_grant,
  output logic [1:0] grant
);

  always_comb begin
    grant = 2'b00;
    case (valid)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = last_grant ? 2'b01 : 2'b10;
      default: grant = 2'b00;
    endcase
  end

endmodule

// File: rtl/or_reduce_sched.sv
// Arbitrates two requesters and OR-reduces the accepted operand one byte per cycle
// through an external shared 8-input OR reducer, stopping early on the first set byte.
module or_reduce_sched
  import or_sched_pkg::*;
#(parameter int WIDTH = DATA_WIDTH)
(
  input logic               clock,
  input logic               reset,
  or_reduce_sched_if.slave  bus
);

  localparam int NSLICE = slices_of(WIDTH);
  localparam int CW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;

  state_t                  state;
  state_t                  state_next;
  logic [NSLICE-1:0][7:0]  operand;
  logic [CW-1:0]           cnt;
  logic                    acc;
  logic                    owner;
  logic                    last_grant;
  logic [1:0]              grant;
  logic                    scan_end;

  rr_arb2 u_arb (
    .valid      ({bus.req1_valid, bus.req0_valid}),
    .last_grant (last_grant),
    .grant      (grant)
  );

  assign scan_end   = bus.red_out || (cnt == CW'(NSLICE - 1));
  assign bus.res_or = acc;
  assign bus.res_id = owner;

  // Readies exist only in IDLE, so nothing is accepted while a result is pending or leaving.
  always_comb begin
    state_next     = state;
    bus.req0_ready = 1'b0;
    bus.req1_ready = 1'b0;
    bus.res_valid  = 1'b0;
    bus.red_in     = 8'h00;
    bus.busy       = (state != IDLE);
    case (state)
      IDLE: begin
        bus.req0_ready = grant[0];
        bus.req1_ready = grant[1];
        if (|grant) state_next = SCAN;
      end
      SCAN: begin
        bus.red_in = operand[cnt];
        if (scan_end) state_next = DONE;
      end
      DONE: begin
        bus.res_valid = 1'b1;
        if (bus.res_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      cnt        <= '0;
      acc        <= 1'b0;
      operand    <= '0;
      owner      <= 1'b0;
      last_grant <= 1'b1;
    end else begin
      state <= state_next;
      case (state)
        IDLE: begin
          if (|grant) begin
            operand <= grant[1] ? bus.req1_data : bus.req0_data;
            owner   <= grant[1];
            cnt     <= '0;
            acc     <= 1'b0;
          end
        end
        SCAN: begin
          acc <= acc | bus.red_out;
          if (!scan_end) cnt <= cnt + 1'b1;
        end
        DONE: begin
          if (bus.res_ready) last_grant <= owner;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_or_reduce_sched.sv
// Self-checking bench for or_reduce_sched: directed table, reset/arbitration sequences, random traffic.
module tb_or_reduce_sched;
  import or_sched_pkg::*;

  logic clock;
  logic reset;
  int   total;
  int   bad;
  logic model_last;

  or_reduce_sched_if #(.WIDTH(32)) bus ();

  or_reduce_sched #(.WIDTH(32)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  assign bus.red_out = |bus.red_in;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  typedef struct {
    logic        v0;
    logic        v1;
    logic [31:0] d0;
    logic [31:0] d1;
    int          stall;
    int          exp_id;
    logic        exp_or;
    int          exp_lat;
    logic [31:0] exp_red;
  } vec_t;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
    end
  endtask

  // Number of slices the scan visits: up to and including the first non-zero byte.
  function automatic int model_k(input logic [31:0] x);
    for (int i = 0; i < SLICES; i++)
      if (((x >> (8 * i)) & 32'hff) != 0) return i + 1;
    return SLICES;
  endfunction

  function automatic logic [31:0] model_red(input logic [31:0] x);
    return x & 32'((64'd1 << (8 * model_k(x))) - 64'd1);
  endfunction

  function automatic int model_grant(input logic v0, input logic v1, input logic last);
    if (v0 && v1) return last ? 0 : 1;
    if (v0) return 0;
    if (v1) return 1;
    return -1;
  endfunction

  // Runs one transaction starting in an IDLE cycle (just after a rising edge).
  task automatic applyStimulus(input logic v0, input logic v1, input logic [31:0] d0,
                               input logic [31:0] d1, input bit keep, input int stall,
                               output int gid, output int lat, output logic ror,
                               output logic rid, output logic [31:0] redseq, output int viol);
    int nscan;
    gid = -1; lat = 0; ror = 1'b0; rid = 1'b0; redseq = '0; viol = 0; nscan = 0;
    bus.req0_valid = v0; bus.req1_valid = v1;
    bus.req0_data  = d0; bus.req1_data  = d1;
    bus.res_ready  = 1'b0;
    #1;
    if (bus.req0_ready && bus.req1_ready) viol++;
    if (bus.req0_ready) gid = 0;
    else if (bus.req1_ready) gid = 1;
    @(posedge clock); #1;
    if (!keep) begin
      bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
    end
    bus.req0_data = $urandom; bus.req1_data = $urandom;
    if (gid < 0) return;
    forever begin
      lat++;
      #1;
      if (bus.req0_ready || bus.req1_ready) viol++;
      if (bus.res_valid || lat > 20) break;
      if (nscan < SLICES) redseq = redseq | (32'(bus.red_in) << (8 * nscan));
      nscan++;
      @(posedge clock); #1;
    end
    ror = bus.res_or; rid = bus.res_id;
    for (int s = 0; s < stall; s++) begin
      @(posedge clock); #2;
      if (bus.res_valid !== 1'b1 || bus.res_or !== ror || bus.res_id !== rid) viol++;
      if (bus.busy !== 1'b1 || bus.req0_ready || bus.req1_ready) viol++;
    end
    bus.res_ready = 1'b1;
    #1;
    if (bus.req0_ready || bus.req1_ready) viol++;
    @(posedge clock); #1;
    bus.res_ready = 1'b0;
    if (bus.res_valid !== 1'b0 || bus.busy !== 1'b0) viol++;
  endtask

  task automatic doReset();
    bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
    bus.req0_data = '0; bus.req1_data = '0; bus.res_ready = 1'b0;
    reset = 1'b0;
    repeat (2) @(posedge clock);
    #1 reset = 1'b1;
    model_last = 1'b1;
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_res_valid"}, 32'(bus.res_valid), 0);
    checkOutput({tag, "_res_or"},    32'(bus.res_or), 0);
    checkOutput({tag, "_res_id"},    32'(bus.res_id), 0);
    checkOutput({tag, "_busy"},      32'(bus.busy), 0);
    checkOutput({tag, "_ready0"},    32'(bus.req0_ready), 0);
    checkOutput({tag, "_ready1"},    32'(bus.req1_ready), 0);
    checkOutput({tag, "_red_in"},    32'(bus.red_in), 0);
  endtask

  initial begin
    vec_t        vecs[5];
    int          gid, lat, viol, eid, k, seen;
    logic        ror, rid;
    logic [31:0] redseq, d0, d1;
    logic        v0, v1;
    int          exp_order[3];

    total = 0; bad = 0;
    reset = 1'b1;
    bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
    bus.req0_data = '0; bus.req1_data = '0; bus.res_ready = 1'b0;
    #2 reset = 1'b0;
    #3;
    checkResetOutputs("reset");
    @(posedge clock); #1 reset = 1'b1;
    model_last = 1'b1;

    vecs[0] = '{1'b1, 1'b0, 32'h0000_0000, 32'h0,         0,  0, 1'b0, 5, 32'h0000_0000};
    vecs[1] = '{1'b0, 1'b1, 32'h0,         32'h0000_0001, 0,  1, 1'b1, 2, 32'h0000_0001};
    vecs[2] = '{1'b1, 1'b0, 32'h8000_0000, 32'h0,         0,  0, 1'b1, 5, 32'h8000_0000};
    vecs[3] = '{1'b1, 1'b1, 32'h00ff_0000, 32'h0000_ab00, 1,  1, 1'b1, 3, 32'h0000_ab00};
    vecs[4] = '{1'b1, 1'b1, 32'h0012_0000, 32'h0000_0000, 10, 0, 1'b1, 4, 32'h0012_0000};

    for (int i = 0; i < 5; i++) begin
      applyStimulus(vecs[i].v0, vecs[i].v1, vecs[i].d0, vecs[i].d1, 1'b0, vecs[i].stall,
                    gid, lat, ror, rid, redseq, viol);
      checkOutput($sformatf("vec%0d_grant", i), 32'(gid), 32'(vecs[i].exp_id));
      checkOutput($sformatf("vec%0d_latency", i), 32'(lat), 32'(vecs[i].exp_lat));
      checkOutput($sformatf("vec%0d_res_or", i), 32'(ror), 32'(vecs[i].exp_or));
      checkOutput($sformatf("vec%0d_res_id", i), 32'(rid), 32'(vecs[i].exp_id));
      checkOutput($sformatf("vec%0d_red_seq", i), redseq, vecs[i].exp_red);
      checkOutput($sformatf("vec%0d_protocol", i), 32'(viol), 0);
    end

    // Reset in the second SCAN cycle abandons the operation.
    bus.req0_valid = 1'b1; bus.req0_data = 32'h0;
    @(posedge clock); #1;
    bus.req0_valid = 1'b0;
    @(posedge clock); #1;
    checkOutput("midscan_busy_before", 32'(bus.busy), 1);
    reset = 1'b0;
    #1;
    checkResetOutputs("midscan");
    @(posedge clock); #1 reset = 1'b1;
    model_last = 1'b1;
    seen = 0;
    repeat (8) begin
      @(posedge clock); #1;
      if (bus.res_valid || bus.busy) seen++;
    end
    checkOutput("midscan_no_result", 32'(seen), 0);

    // Both requesters held high for three back-to-back transactions.
    exp_order = '{0, 1, 0};
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 1'b1, 32'h0000_0100, 32'h0000_0100, 1'b1, 0,
                    gid, lat, ror, rid, redseq, viol);
      checkOutput($sformatf("rr%0d_grant", i), 32'(gid), 32'(exp_order[i]));
      checkOutput($sformatf("rr%0d_protocol", i), 32'(viol), 0);
      model_last = logic'(exp_order[i]);
    end
    bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;

    for (int i = 0; i < 24; i++) begin
      d0 = $urandom; d1 = $urandom;
      for (int b = 0; b < 4; b++) begin
        if ($urandom_range(0, 1) == 0) d0 = d0 & ~(32'hff << (8 * b));
        if ($urandom_range(0, 1) == 0) d1 = d1 & ~(32'hff << (8 * b));
      end
      case ($urandom_range(0, 2))
        0: begin v0 = 1'b1; v1 = 1'b0; end
        1: begin v0 = 1'b0; v1 = 1'b1; end
        default: begin v0 = 1'b1; v1 = 1'b1; end
      endcase
      eid = model_grant(v0, v1, model_last);
      k = model_k(eid == 1 ? d1 : d0);
      applyStimulus(v0, v1, d0, d1, bit'($urandom_range(0, 1)), $urandom_range(0, 3),
                    gid, lat, ror, rid, redseq, viol);
      checkOutput($sformatf("rand%0d_grant", i), 32'(gid), 32'(eid));
      checkOutput($sformatf("rand%0d_latency", i), 32'(lat), 32'(k + 1));
      checkOutput($sformatf("rand%0d_res_or", i), 32'(ror), 32'((eid == 1 ? d1 : d0) != 0));
      checkOutput($sformatf("rand%0d_res_id", i), 32'(rid), 32'(eid));
      checkOutput($sformatf("rand%0d_red_seq", i), redseq, model_red(eid == 1 ? d1 : d0));
      checkOutput($sformatf("rand%0d_protocol", i), 32'(viol), 0);
      model_last = logic'(eid);
      bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
